// File: rtl/exe_issue_buf_pkg.sv
// rtl/exe_issue_buf_pkg.sv - widths, occupancy codes and entry layout for the EX issue buffer
package exe_issue_buf_pkg;

  localparam int XLEN        = 64;
  localparam int OP_W        = 8;
  localparam int ALU_W       = 10;
  localparam int RIDX_W      = 5;
  localparam int ISSUE_DEPTH = 2;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic              rs1_en;
    logic              rs2_en;
    logic [OP_W-1:0]   op_info;
    logic [ALU_W-1:0]  alu_info;
    logic              word;
  } issue_entry_t;

  // x0 is hardwired zero, so a writeback to it never forwards.
  function automatic logic rs_hit(input logic en, input logic [RIDX_W-1:0] rs,
                                  input logic wb_valid, input logic [RIDX_W-1:0] wb_rd);
    return en && wb_valid && (wb_rd != '0) && (rs == wb_rd);
  endfunction

endpackage

// File: rtl/issue_bypass_mux.sv
// rtl/issue_bypass_mux.sv - patches one entry's operands from the writeback port
module issue_bypass_mux
  import exe_issue_buf_pkg::*;
(
  input  issue_entry_t      entry_in,
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output issue_entry_t      entry_out
);

  always_comb begin
    entry_out = entry_in;
    if (rs_hit(entry_in.rs1_en, entry_in.rs1, wb_valid, wb_rd)) entry_out.op1 = wb_data;
    if (rs_hit(entry_in.rs2_en, entry_in.rs2, wb_valid, wb_rd)) entry_out.op2 = wb_data;
  end

endmodule

// File: rtl/exe_issue_buf.sv
// rtl/exe_issue_buf.sv - two-entry skid buffer between decode and the EX-stage ALU
module exe_issue_buf
  import exe_issue_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_op1,
  input  logic [XLEN-1:0]   in_op2,
  input  logic [RIDX_W-1:0] in_rs1,
  input  logic [RIDX_W-1:0] in_rs2,
  input  logic              in_rs1_use,
  input  logic              in_rs2_use,
  input  logic [OP_W-1:0]   in_op_info,
  input  logic [ALU_W-1:0]  in_alu_info,
  input  logic              in_word,
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [OP_W-1:0]   out_op_info,
  output logic [ALU_W-1:0]  out_alu_info,
  output logic              out_word
);

  logic [1:0]   count;
  issue_entry_t head_q, skid_q;
  issue_entry_t in_entry, head_byp, skid_byp, in_byp;
  logic         push, pop;

  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != CNT_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_entry          = '0;
    in_entry.op1      = in_op1;
    in_entry.op2      = in_op2;
    in_entry.rs1      = in_rs1;
    in_entry.rs2      = in_rs2;
    in_entry.rs1_en   = in_rs1_use;
    in_entry.rs2_en   = in_rs2_use;
    in_entry.op_info  = in_op_info;
    in_entry.alu_info = in_alu_info;
    in_entry.word     = in_word;
  end

  issue_bypass_mux u_byp_head (
    .entry_in(head_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .entry_out(head_byp)
  );
  issue_bypass_mux u_byp_skid (
    .entry_in(skid_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .entry_out(skid_byp)
  );
  issue_bypass_mux u_byp_in (
    .entry_in(in_entry), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .entry_out(in_byp)
  );

  // Slots always reload through their bypass mux so a waiting entry picks up writebacks;
  // a departing head is simply overwritten, so the ALU sees its pre-bypass value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= CNT_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      count <= CNT_EMPTY;
    end else begin
      head_q <= head_byp;
      skid_q <= skid_byp;
      case (count)
        CNT_EMPTY: begin
          if (push) begin
            head_q <= in_byp;
            count  <= CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            head_q <= in_byp;
          end else if (push) begin
            skid_q <= in_byp;
            count  <= CNT_FULL;
          end else if (pop) begin
            count <= CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            head_q <= skid_byp;
            count  <= CNT_ONE;
          end
        end
        default: count <= CNT_EMPTY;
      endcase
    end
  end

  // Idle outputs read as zero so the ALU decode sees no operation.
  assign out_op1      = out_valid ? head_q.op1      : '0;
  assign out_op2      = out_valid ? head_q.op2      : '0;
  assign out_op_info  = out_valid ? head_q.op_info  : '0;
  assign out_alu_info = out_valid ? head_q.alu_info : '0;
  assign out_word     = out_valid ? head_q.word     : 1'b0;

endmodule

// File: tb/tb_exe_issue_buf.sv
// tb/tb_exe_issue_buf.sv - vector-table bench for exe_issue_buf
module tb_exe_issue_buf;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [63:0] in_op1, in_op2;
  logic [4:0]  in_rs1, in_rs2;
  logic        in_rs1_use, in_rs2_use;
  logic [7:0]  in_op_info;
  logic [9:0]  in_alu_info;
  logic        in_word;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        out_valid, out_ready;
  logic [63:0] out_op1, out_op2;
  logic [7:0]  out_op_info;
  logic [9:0]  out_alu_info;
  logic        out_word;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  exe_issue_buf dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .in_op_info(in_op_info), .in_alu_info(in_alu_info), .in_word(in_word),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_op_info(out_op_info),
    .out_alu_info(out_alu_info), .out_word(out_word)
  );

  typedef struct {
    logic        rst_n, flush, iv, ordy;
    logic [63:0] op1, op2;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [7:0]  info;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [63:0] wbd;
    logic        ev, er;
    logic [63:0] eo1, eo2;
    logic [7:0]  einfo;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic fl, input logic iv, input logic ordy,
                     input logic [63:0] op1, input logic [63:0] op2,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [7:0] info, input logic wbv, input logic [4:0] wbrd,
                     input logic [63:0] wbd, input logic ev, input logic er,
                     input logic [63:0] eo1, input logic [63:0] eo2, input logic [7:0] einfo);
    vec_t v;
    v.rst_n = r; v.flush = fl; v.iv = iv; v.ordy = ordy; v.op1 = op1; v.op2 = op2;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.info = info;
    v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
    v.ev = ev; v.er = er; v.eo1 = eo1; v.eo2 = eo2; v.einfo = einfo;
    vq.push_back(v);
  endtask

  // ALU one-hot and word flag are derived from the info tag on both drive and expect sides.
  function automatic logic [9:0] alu_of(input logic [7:0] info);
    return 10'h1 << (info % 8'd10);
  endfunction

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; flush = v.flush; in_valid = v.iv; out_ready = v.ordy;
    in_op1 = v.op1; in_op2 = v.op2; in_rs1 = v.rs1; in_rs1_use = v.u1;
    in_rs2 = v.rs2; in_rs2_use = v.u2; in_op_info = v.info;
    in_alu_info = alu_of(v.info); in_word = v.info[0];
    wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pack_act();
    return {11'd0, out_valid, in_ready, out_op1, out_op2, out_op_info, out_alu_info, out_word};
  endfunction

  function automatic logic [159:0] pack_exp(input vec_t v);
    logic [9:0] ea;
    logic       ew;
    ea = v.ev ? alu_of(v.einfo) : 10'd0;
    ew = v.ev ? v.einfo[0] : 1'b0;
    return {11'd0, v.ev, v.er, v.eo1, v.eo2, v.einfo, ea, ew};
  endfunction

  task automatic push_hand(input logic [63:0] op1, input logic [4:0] rs1);
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_op1 = op1; in_op2 = '0; in_rs1 = rs1; in_rs1_use = 1'b1; in_rs2 = '0; in_rs2_use = 1'b0;
    in_op_info = op1[7:0]; in_alu_info = alu_of(op1[7:0]); in_word = op1[0];
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  initial begin
    int waited;
    vec_t z;
    z = '{default: '0};
    drive(z);

    // reset
    add(0,0,0,0, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // streaming: one entry per cycle, zero bubbles
    for (int k = 1; k <= 8; k++)
      add(1,0,1,1, 64'(k),64'(k+16), 0,0,0,0, 8'(k), 0,0,0, 1,1, 64'(k),64'(k+16),8'(k));
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // backpressure
    add(1,0,1,0, 64'hA,64'h1A, 0,0,0,0, 8'h0A, 0,0,0, 1,1, 64'hA,64'h1A,8'h0A);
    add(1,0,1,0, 64'hB,64'h1B, 0,0,0,0, 8'h0B, 0,0,0, 1,0, 64'hA,64'h1A,8'h0A);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 1,1, 64'hB,64'h1B,8'h0B);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // bypass on a held head, including x0 and op2
    add(1,0,1,0, 64'h0,64'h22, 5,1,7,1, 8'h05, 0,0,0, 1,1, 64'h0,64'h22,8'h05);
    add(1,0,0,0, 0,0, 0,0,0,0, 8'h00, 1,5,64'hDEAD, 1,1, 64'hDEAD,64'h22,8'h05);
    add(1,0,0,0, 0,0, 0,0,0,0, 8'h00, 1,0,64'hBEEF, 1,1, 64'hDEAD,64'h22,8'h05);
    add(1,0,0,0, 0,0, 0,0,0,0, 8'h00, 1,7,64'h77, 1,1, 64'hDEAD,64'h77,8'h05);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // rs1_use=0 is not bypassed
    add(1,0,1,0, 64'h3,64'h4, 5,0,6,0, 8'h06, 0,0,0, 1,1, 64'h3,64'h4,8'h06);
    add(1,0,0,0, 0,0, 0,0,0,0, 8'h00, 1,5,64'hBEEF, 1,1, 64'h3,64'h4,8'h06);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // bypass applied to the entry being pushed
    add(1,0,1,0, 64'h1,64'h2, 9,1,9,1, 8'h09, 1,9,64'h99, 1,1, 64'h99,64'h99,8'h09);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // mid-stream reset from FULL
    add(1,0,1,0, 64'h11,64'h12, 0,0,0,0, 8'h11, 0,0,0, 1,1, 64'h11,64'h12,8'h11);
    add(1,0,1,0, 64'h21,64'h22, 0,0,0,0, 8'h21, 0,0,0, 1,0, 64'h11,64'h12,8'h11);
    add(0,0,0,0, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // flush from FULL with in_valid, then from ONE with a live push
    add(1,0,1,0, 64'h31,64'h32, 0,0,0,0, 8'h31, 0,0,0, 1,1, 64'h31,64'h32,8'h31);
    add(1,0,1,0, 64'h41,64'h42, 0,0,0,0, 8'h41, 0,0,0, 1,0, 64'h31,64'h32,8'h31);
    add(1,1,1,1, 64'h51,64'h52, 0,0,0,0, 8'h51, 0,0,0, 0,1, 0,0,8'h00);
    add(1,0,1,0, 64'h61,64'h62, 0,0,0,0, 8'h61, 0,0,0, 1,1, 64'h61,64'h62,8'h61);
    add(1,1,1,0, 64'h71,64'h72, 0,0,0,0, 8'h71, 0,0,0, 0,1, 0,0,8'h00);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);
    // pop + bypass collision: departing head keeps 7, skid takes wb_data
    add(1,0,1,0, 64'h7,64'h0, 3,1,0,0, 8'h07, 0,0,0, 1,1, 64'h7,64'h0,8'h07);
    add(1,0,1,0, 64'h8,64'h0, 3,1,0,0, 8'h08, 0,0,0, 1,0, 64'h7,64'h0,8'h07);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 1,3,64'h33, 1,1, 64'h33,64'h0,8'h08);
    add(1,0,0,1, 0,0, 0,0,0,0, 8'h00, 0,0,0, 0,1, 0,0,8'h00);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), pack_act(), pack_exp(vq[i]));
    end

    // Hand sequence: ALU sees the pre-bypass head during a colliding pop.
    push_hand(64'h7, 5'd3);
    push_hand(64'h8, 5'd3);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
    #1;
    chk("coll_pre_op1", {96'd0, out_op1}, {96'd0, 64'h7});
    chk("coll_pre_valid", {159'd0, out_valid}, 160'd1);
    @(posedge clk);
    #1;
    chk("coll_post_op1", {96'd0, out_op1}, {96'd0, 64'h33});
    @(negedge clk);
    wb_valid = 1'b0;
    waited = 0;
    while (out_valid && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_bound", {159'd0, out_valid}, 160'd0);
    chk("drain_ready", {159'd0, in_ready}, 160'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
